// File: rtl/alarm_timekeeper.sv
// -----------------------------------------------------------------------------
// alarm_timekeeper
//
// 24-hour HH:MM:SS timekeeper with one HH:MM alarm and a buzzer output.
// Everything runs on Clk; the 1 Hz Sec_clk is treated as an asynchronous data
// input. It is synchronised and edge-detected into a one-cycle tick.
//
// Optional feature: define ALARM_SNOOZE_EN to build the SNOOZE state, its
// counter and the Snooze input. Without it, Snooze is accepted and ignored.
//
// Ports:
//   Clk        in   system clock (50 MHz)
//   Rst_n      in   synchronous active-low reset
//   Sec_clk    in   1 Hz square wave, async; each rising edge is one second
//   Mode       in   00/11 run, 01 set time, 10 set alarm
//   Inc_min    in   pulse: +1 minute of the register selected by Mode
//   Inc_hr     in   pulse: +1 hour of the register selected by Mode
//   Alarm_on   in   level: alarm armed
//   Stop       in   pulse: silence the alarm
//   Snooze     in   pulse: snooze (ALARM_SNOOZE_EN builds only)
//   Hours      out  current hour 0..23
//   Minutes    out  current minute 0..59
//   Seconds    out  current second 0..59
//   Al_hours   out  alarm hour
//   Al_minutes out  alarm minute
//   Buzzer     out  1 while ringing
//   Dbg_state  out  FSM state register (0 IDLE, 1 RINGING, 2 SNOOZE)
//
// Handshake: there are no valid/ready channels; Inc_min, Inc_hr, Stop and
// Snooze are single-cycle pulses acted on at the Clk edge where they are high.
// -----------------------------------------------------------------------------
module alarm_timekeeper #(
  parameter int RING_SECS     = 60,
  parameter int SNOOZE_MIN    = 5,
  parameter int ALARM_RST_HR  = 6,
  parameter int ALARM_RST_MIN = 0
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Sec_clk,
  input  logic [1:0] Mode,
  input  logic       Inc_min,
  input  logic       Inc_hr,
  input  logic       Alarm_on,
  input  logic       Stop,
  input  logic       Snooze,
  output logic [4:0] Hours,
  output logic [5:0] Minutes,
  output logic [5:0] Seconds,
  output logic [4:0] Al_hours,
  output logic [5:0] Al_minutes,
  output logic       Buzzer,
  output logic [1:0] Dbg_state
);

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1
  } state_t;

  logic unused_snooze;
  assign unused_snooze = Snooze;
`endif

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Sec_clk synchroniser and rising-edge detector. All three flops reset to 1
  // so a Sec_clk that is already high when reset releases is not seen as an
  // edge.
  // ---------------------------------------------------------------------------
  logic sync1, sync2, hist;
  logic tick;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= Sec_clk;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign tick = sync2 & ~hist;

  logic set_time, set_alarm;
  assign set_time  = (Mode == 2'b01);
  assign set_alarm = (Mode == 2'b10);

  // ---------------------------------------------------------------------------
  // Time of day
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Hours   <= '0;
      Minutes <= '0;
      Seconds <= '0;
    end else if (set_time) begin
      Seconds <= '0;
      if (Inc_min) Minutes <= (Minutes == 6'd59) ? 6'd0 : Minutes + 6'd1;
      if (Inc_hr)  Hours   <= (Hours == 5'd23)   ? 5'd0 : Hours + 5'd1;
    end else if (tick) begin
      if (Seconds == 6'd59) begin
        Seconds <= '0;
        if (Minutes == 6'd59) begin
          Minutes <= '0;
          Hours   <= (Hours == 5'd23) ? 5'd0 : Hours + 5'd1;
        end else begin
          Minutes <= Minutes + 6'd1;
        end
      end else begin
        Seconds <= Seconds + 6'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm time register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Al_hours   <= 5'(ALARM_RST_HR);
      Al_minutes <= 6'(ALARM_RST_MIN);
    end else if (set_alarm) begin
      if (Inc_min) Al_minutes <= (Al_minutes == 6'd59) ? 6'd0 : Al_minutes + 6'd1;
      if (Inc_hr)  Al_hours   <= (Al_hours == 5'd23)   ? 5'd0 : Al_hours + 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Trigger: compare only in the cycle right after a tick advanced the time.
  // Tying the compare to the tick stops the alarm from re-firing for the rest
  // of the matching second and stops set-time edits from ever firing it.
  // ---------------------------------------------------------------------------
  logic tick_d;
  logic trigger;

  always_ff @(posedge Clk) begin
    if (!Rst_n) tick_d <= 1'b0;
    else        tick_d <= tick & ~set_time;
  end

  assign trigger = tick_d & Alarm_on & ~set_time &
                   (Hours == Al_hours) & (Minutes == Al_minutes) &
                   (Seconds == 6'd0);

  // ---------------------------------------------------------------------------
  // Ring / snooze FSM
  // ---------------------------------------------------------------------------
  logic [7:0] ring_cnt;
`ifdef ALARM_SNOOZE_EN
  logic [11:0] snz_cnt;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trigger) state_d = RINGING;
      end
      RINGING: begin
        if (Stop)           state_d = IDLE;
        else if (!Alarm_on) state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (Snooze)    state_d = SNOOZE;
`endif
        else if (tick && ring_cnt == 8'(RING_SECS - 1)) state_d = IDLE;
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (Stop || !Alarm_on) state_d = IDLE;
        else if (tick && snz_cnt == 12'(SNZ_TICKS - 1)) state_d = RINGING;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      Buzzer  <= 1'b0;
    end else begin
      state_q <= state_d;
      Buzzer  <= (state_d == RINGING);
    end
  end

  // Counters run only while the FSM stays in their state; any entry clears.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ring_cnt <= '0;
    end else if (state_q == RINGING && state_d == RINGING) begin
      if (tick) ring_cnt <= ring_cnt + 8'd1;
    end else begin
      ring_cnt <= '0;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      snz_cnt <= '0;
    end else if (state_q == SNOOZE && state_d == SNOOZE) begin
      if (tick) snz_cnt <= snz_cnt + 12'd1;
    end else begin
      snz_cnt <= '0;
    end
  end
`endif

  assign Dbg_state = state_q;

endmodule

// File: tb/tb_alarm_timekeeper.sv
module tb_alarm_timekeeper;

  localparam int RING_SECS  = 60;
  localparam int SNOOZE_MIN = 5;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_clk = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       inc_min = 1'b0, inc_hr = 1'b0;
  logic       alarm_on = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic [4:0] hours, al_hours;
  logic [5:0] minutes, seconds, al_minutes;
  logic       buzzer;
  logic [1:0] dbg_state;

  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alarm_timekeeper #(
    .RING_SECS(RING_SECS), .SNOOZE_MIN(SNOOZE_MIN),
    .ALARM_RST_HR(6), .ALARM_RST_MIN(0)
  ) dut (
    .Clk(clk), .Rst_n(rst_n), .Sec_clk(sec_clk), .Mode(mode),
    .Inc_min(inc_min), .Inc_hr(inc_hr), .Alarm_on(alarm_on),
    .Stop(stop), .Snooze(snooze),
    .Hours(hours), .Minutes(minutes), .Seconds(seconds),
    .Al_hours(al_hours), .Al_minutes(al_minutes),
    .Buzzer(buzzer), .Dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Reference model: time of day in seconds, alarm in minutes of the day,
  // alarm activity as idle / ringing / snoozed with elapsed-second counts.
  // ---------------------------------------------------------------------------
  int m_tod, m_al, m_mode, m_state, m_ring, m_snz;
  bit m_alarm_on;
  localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag);
    check({tag, "_hr"},  32'(hours),   32'(m_tod / 3600));
    check({tag, "_min"}, 32'(minutes), 32'((m_tod / 60) % 60));
    check({tag, "_sec"}, 32'(seconds), 32'(m_tod % 60));
    check({tag, "_alh"}, 32'(al_hours),   32'(m_al / 60));
    check({tag, "_alm"}, 32'(al_minutes), 32'(m_al % 60));
  endtask

  task automatic check_buz(input string tag);
    check({tag, "_buz"}, 32'(buzzer), 32'(m_state == M_RING));
  endtask

  task automatic model_reset();
    m_tod = 0; m_al = 6 * 60; m_state = M_IDLE; m_ring = 0; m_snz = 0;
  endtask

  task automatic model_tick();
    if (m_mode != 1) m_tod = (m_tod + 1) % 86400;
    if (m_state == M_RING) begin
      m_ring++;
      if (m_ring == RING_SECS) m_state = M_IDLE;
    end else if (m_state == M_SNZ) begin
      m_snz++;
      if (m_snz == SNOOZE_MIN * 60) begin m_state = M_RING; m_ring = 0; end
    end
    if (m_mode != 1 && m_alarm_on && m_state == M_IDLE && m_tod == m_al * 60) begin
      m_state = M_RING; m_ring = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all drive at posedge+1 and return at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic sec_tick();
    sec_clk = 1'b1;
    repeat (3) @(posedge clk);
    model_tick();
    @(negedge clk);
    check_time("tick");
    @(posedge clk);
    @(negedge clk);
    check_buz("tick");
    sec_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int md);
    mode = 2'(md);
    @(posedge clk); #1;
    m_mode = md;
    if (md == 1) m_tod = m_tod - (m_tod % 60);
  endtask

  task automatic pulse_inc(input bit m, input bit h);
    int hh, mm;
    inc_min = m; inc_hr = h;
    @(posedge clk); #1;
    inc_min = 1'b0; inc_hr = 1'b0;
    if (m_mode == 1) begin
      hh = m_tod / 3600; mm = (m_tod / 60) % 60;
      if (m) mm = (mm + 1) % 60;
      if (h) hh = (hh + 1) % 24;
      m_tod = hh * 3600 + mm * 60;
    end else if (m_mode == 2) begin
      hh = m_al / 60; mm = m_al % 60;
      if (m) mm = (mm + 1) % 60;
      if (h) hh = (hh + 1) % 24;
      m_al = hh * 60 + mm;
    end
  endtask

  task automatic set_alarm_on(input bit v);
    alarm_on = v;
    @(posedge clk); #1;
    m_alarm_on = v;
    if (!v) m_state = M_IDLE;
  endtask

  task automatic pulse_stop_snooze(input bit st, input bit sn);
    stop = st; snooze = sn;
    @(posedge clk); #1;
    stop = 1'b0; snooze = 1'b0;
    if (m_state != M_IDLE) begin
      if (st || !m_alarm_on) m_state = M_IDLE;
      else if (sn && SNZ_EN && m_state == M_RING) begin m_state = M_SNZ; m_snz = 0; end
    end
  endtask

  // Bring time to one minute before the alarm and run into it.
  task automatic arm_ring();
    int target, th, tm;
    set_mode(1);
    target = (m_al * 60 - 60 + 86400) % 86400;
    th = target / 3600; tm = (target / 60) % 60;
    while (((m_tod / 60) % 60) != tm) pulse_inc(1'b1, 1'b0);
    while ((m_tod / 3600) != th) pulse_inc(1'b0, 1'b1);
    set_mode(0);
    set_alarm_on(1'b1);
    repeat (60) sec_tick();
    check("arm_ringing", 32'(buzzer), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    m_mode = 0; m_alarm_on = 1'b0;
    model_reset();

    // Reset with Sec_clk held high: no false tick after release.
    sec_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_hours", 32'(hours), 32'd0);
    check("rst_minutes", 32'(minutes), 32'd0);
    check("rst_seconds", 32'(seconds), 32'd0);
    check("rst_al_hours", 32'(al_hours), 32'd6);
    check("rst_al_minutes", 32'(al_minutes), 32'd0);
    check("rst_buzzer", 32'(buzzer), 32'd0);
    sec_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("fall_no_tick", 32'(seconds), 32'd0);

    // Tick latency from Sec_clk rise to Seconds update.
    sec_clk = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (seconds != 6'd0) break;
    end
    check("tick_latency_ok", 32'(lat >= 2 && lat <= 3), 32'd1);
    model_tick();
    sec_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_time("after_latency");

    // Set 23:59 and run across midnight.
    set_mode(1);
    repeat (23) pulse_inc(1'b0, 1'b1);
    repeat (59) pulse_inc(1'b1, 1'b0);
    set_mode(0);
    repeat (59) sec_tick();
    check("pre_wrap", 32'({hours, minutes, seconds}), 32'({5'd23, 6'd59, 6'd59}));
    sec_tick();
    check("midnight", 32'({hours, minutes, seconds}), 32'd0);

    // Set-time boundaries: minute wrap without carry, ticks ignored, dual pulse.
    set_mode(1);
    repeat (59) pulse_inc(1'b1, 1'b0);
    check("set_min59", 32'(minutes), 32'd59);
    pulse_inc(1'b1, 1'b0);
    @(negedge clk);
    check("set_min_wrap", 32'(minutes), 32'd0);
    check("set_min_nocarry", 32'(hours), 32'd0);
    repeat (3) sec_tick();
    check("set_sec_frozen", 32'(seconds), 32'd0);
    pulse_inc(1'b1, 1'b1);
    @(negedge clk);
    check("set_both", 32'({hours, minutes}), 32'({5'd1, 6'd1}));

    // Alarm 00:02, time 00:01:00, ring then auto-stop.
    set_mode(2);
    while (m_al / 60 != 0) pulse_inc(1'b0, 1'b1);
    while (m_al % 60 != 2) pulse_inc(1'b1, 1'b0);
    check("alarm_set", 32'({al_hours, al_minutes}), 32'({5'd0, 6'd2}));
    set_mode(1);
    repeat (23) pulse_inc(1'b0, 1'b1);
    set_mode(0);
    set_alarm_on(1'b1);
    repeat (59) sec_tick();
    check("before_match", 32'(buzzer), 32'd0);
    sec_tick();
    check("ring_start", 32'(buzzer), 32'd1);
    repeat (60) sec_tick();
    check("ring_timeout", 32'(buzzer), 32'd0);

    // Stop at the 10th ringing tick; no retrigger afterwards.
    arm_ring();
    repeat (10) sec_tick();
    pulse_stop_snooze(1'b1, 1'b0);
    @(negedge clk);
    check("stop_buz", 32'(buzzer), 32'd0);
    repeat (20) sec_tick();

    // Stop and Snooze together -> idle.
    arm_ring();
    repeat (3) sec_tick();
    pulse_stop_snooze(1'b1, 1'b1);
    @(negedge clk);
    check("stop_snooze_buz", 32'(buzzer), 32'd0);
    repeat (3) sec_tick();

    // Alarm_on dropped mid-ring.
    arm_ring();
    repeat (2) sec_tick();
    set_alarm_on(1'b0);
    @(negedge clk);
    check("alarm_off_buz", 32'(buzzer), 32'd0);
    set_alarm_on(1'b1);

    // Snooze at the 5th ringing tick.
    arm_ring();
    repeat (5) sec_tick();
    pulse_stop_snooze(1'b0, 1'b1);
    @(negedge clk);
    check("snooze_buz", 32'(buzzer), 32'(!SNZ_EN));
    repeat (299) sec_tick();
    check("snooze_299", 32'(buzzer), 32'd0);
    sec_tick();
    check("snooze_300", 32'(buzzer), 32'(SNZ_EN));
    pulse_stop_snooze(1'b1, 1'b0);

    // Reset in the middle of ringing.
    arm_ring();
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_midring_buz", 32'(buzzer), 32'd0);
    check_time("rst_midring");

    // Randomised mix against the model, starting from a ringing alarm.
    arm_ring();
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: sec_tick();
        4: set_mode(int'($urandom_range(0, 3)));
        5, 6: pulse_inc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        7: set_alarm_on(($urandom_range(0, 3) != 0));
        8: pulse_stop_snooze(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        default: begin
          @(negedge clk);
          check_time("rand");
          check_buz("rand");
          @(posedge clk); #1;
        end
      endcase
    end
    @(negedge clk);
    check_time("final");
    check_buz("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_timekeeper.md
Name: alarm_timekeeper

Overview:
- Consumes the divided 1 Hz square wave from the clock divider; keeps 24-hour time as HH:MM:SS.
- Holds an alarm time HH:MM and drives the buzzer.
- Supports set-time and set-alarm modes, stop, and (optionally) snooze.
- Runs entirely on the 50 MHz system clock; the 1 Hz input is a synchronised data input, not a clock.

Parameters:
- RING_SECS, 60: seconds the buzzer sounds before auto-stop (1..255).
- SNOOZE_MIN, 5: snooze length in minutes (1..59).
- ALARM_RST_HR, 6: alarm hour loaded at reset (0..23).
- ALARM_RST_MIN, 0: alarm minute loaded at reset (0..59).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Rst_n  in  1  synchronous active-low reset, sampled on the Clk rising edge.
- Sec_clk  in  1  divided 1 Hz square wave, asynchronous to Clk; each rising edge = one second.
- Mode  in  2  00/11 run, 01 set time, 10 set alarm.
- Inc_min  in  1  single-cycle pulse (pre-debounced): increment minutes of the selected register.
- Inc_hr  in  1  single-cycle pulse: increment hours of the selected register.
- Alarm_on  in  1  level; alarm armed when 1.
- Stop  in  1  single-cycle pulse: silence the alarm.
- Snooze  in  1  single-cycle pulse: snooze (used only with the macro).
- Hours  out  5  current hour 0..23.
- Minutes  out  6  current minute 0..59.
- Seconds  out  6  current second 0..59.
- Al_hours  out  5  alarm hour.
- Al_minutes  out  6  alarm minute.
- Buzzer  out  1  1 while ringing.

Behaviour:
- Reset (Rst_n=0 at a Clk edge):
  - Hours, Minutes and Seconds = 0.
  - Al_hours = ALARM_RST_HR; Al_minutes = ALARM_RST_MIN.
  - Buzzer = 0; FSM = IDLE; ring and snooze counters = 0.
  - Both sync flops and the edge-history flop reset to 1, so a Sec_clk already high at reset produces no false tick.
  - Reset mid-ring drops Buzzer on the same edge.
- Tick generation:
  - Sec_clk passes through a 2-flop synchroniser, then a history flop.
  - tick = sync2 & ~hist, one Clk cycle wide.
  - Seconds updates on the 3rd Clk edge after Sec_clk is first sampled high; latency is fixed and the bench allows 2..3 cycles.
- Run mode (00/11): on tick:
  - Seconds +1; 59 wraps to 0 and carries to Minutes.
  - Minutes 59 wraps to 0 and carries to Hours.
  - Hours 23 wraps to 0.
  - Inc pulses adjust the alarm only in mode 10; in run mode they are ignored.
- Set time (01):
  - Ticks are ignored and Seconds is forced to 0.
  - Inc_min: Minutes +1 mod 60, no carry into Hours.
  - Inc_hr: Hours +1 mod 24.
  - Both pulses in the same cycle: both apply.
- Set alarm (10):
  - Timekeeping continues as in run mode.
  - Inc_min / Inc_hr adjust Al_minutes (mod 60) and Al_hours (mod 24), no carry.
  - Changing the alarm does not affect an alarm already ringing or snoozed.
- Alarm trigger:
  - Fires in the cycle after a tick that moved time to Al_hours:Al_minutes:00, when Alarm_on=1 and Mode!=01.
  - Buzzer rises on the following edge.
  - Reaching the match by setting time never triggers.
- FSM states:
  - IDLE: go to RINGING on trigger; clear the ring counter.
  - RINGING: Buzzer=1; count ticks.
    - Go to IDLE after RING_SECS ticks, on Stop, or on Alarm_on=0.
    - Go to SNOOZE on Snooze (with macro only).
  - SNOOZE: Buzzer=0; count SNOOZE_MIN*60 ticks (12-bit counter), then go to RINGING with the ring counter cleared.
    - Stop or Alarm_on=0 returns to IDLE.
- Priority and boundary rules:
  - Priority: Rst_n > Stop > Alarm_on=0 > Snooze > timeout.
  - Stop in IDLE: no effect.
  - No retrigger during the remainder of the matching second, because the trigger is tick-qualified.
  - A trigger arriving while in RINGING or SNOOZE is ignored.
  - All outputs are registered.

Optional Feature:
- Macro ALARM_SNOOZE_EN.
- Defined: SNOOZE state, its counter and the Snooze input behave as above.
- Undefined:
  - Snooze port remains but is ignored.
  - SNOOZE state and its counter are not synthesised.
  - RINGING exits only via Stop, Alarm_on=0, timeout or reset.

Test Plan:
- Reset with Sec_clk held high, release, keep high 10 cycles -> no tick; outputs 00:00:00, alarm 06:00, Buzzer=0.
- Set time 23:59 (Mode=01, 23 Inc_hr, 59 Inc_min), Mode=00, 60 Sec_clk edges -> 23:59:59 after 59, 00:00:00 after 60.
- Alarm 00:02, Alarm_on=1, time 00:01:00, 60 edges -> Buzzer=1 one cycle after 00:02:00 appears; Buzzer=0 after 60 more edges.
- Ringing, Stop at 10th tick -> Buzzer=0 next edge; no retrigger. Stop+Snooze in the same cycle -> IDLE.
- With ALARM_SNOOZE_EN: Snooze at 5th ringing tick -> Buzzer=0; Buzzer=1 again exactly 300 ticks later. Without the macro -> Snooze ignored, Buzzer stays 1.
- Mode=01 with Minutes=59, Inc_min -> Minutes=0, Hours unchanged; Sec_clk edges leave Seconds=0. Inc_min+Inc_hr in the same cycle -> both increment.
